// File: rtl/data_sync_mc.sv
// -----------------------------------------------------------------------------
// data_sync_mc
//
// Multi-channel enable-qualified data synchroniser with a round-robin output
// merger.
//
// Each channel receives a data slice together with an asynchronous enable (or
// toggle) line. The enable line is synchronised through NUM_STAGES flops and
// then compared against one extra delay flop to detect an event. An event
// captures the channel's slice into its hold register and marks the channel
// pending. A single output register then presents pending words one at a
// time under a valid/ready handshake. Channels are served in round-robin
// order.
//
// Parameters
//   NUM_CH      number of independent channels, 1..16
//   BUS_WIDTH   data width per channel
//   NUM_STAGES  enable synchroniser depth, >= 2
//   TOGGLE_MODE 0: event on rising enable edge, 1: event on any enable edge
//
// Ports
//   CLK         single clock; all state changes on its rising edge
//   RST         synchronous, active-high reset
//   Unsync_bus  channel c data at [c*BUS_WIDTH +: BUS_WIDTH]; the slice must
//               stay stable from its enable change until it is captured
//   bus_enable  per-channel asynchronous enable/toggle
//   out_ready   downstream accept
//   sync_bus    registered output word
//   sync_valid  sync_bus/sync_ch hold a word
//   sync_ch     source channel of sync_bus
//   overrun     sticky per-channel overrun flags
//
// Build option
//   DATA_SYNC_MC_OVERRUN_EN  when defined, overrun[c] sets whenever a new
//                            event on channel c replaces a word that was still
//                            pending and not being granted that cycle; the
//                            flag stays set until reset. When undefined,
//                            overrun is tied to zero and no flops exist.
// -----------------------------------------------------------------------------
module data_sync_mc #(
   parameter int NUM_CH      = 4,
   parameter int BUS_WIDTH   = 8,
   parameter int NUM_STAGES  = 2,
   parameter int TOGGLE_MODE = 0,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus,
   input  logic [NUM_CH-1:0]           bus_enable,
   input  logic                        out_ready,
   output logic [BUS_WIDTH-1:0]        sync_bus,
   output logic                        sync_valid,
   output logic [CH_W-1:0]             sync_ch,
   output logic [NUM_CH-1:0]           overrun
);

   // Synchroniser chains, event-detect delay flops, per-channel holding state
   logic [NUM_STAGES-1:0] en_sync [NUM_CH];
   logic [NUM_CH-1:0]     en_dly;
   logic [NUM_CH-1:0]     ev;
   logic [BUS_WIDTH-1:0]  hold    [NUM_CH];
   logic [NUM_CH-1:0]     pend;

   // Round-robin arbitration state
   logic [CH_W-1:0]       ptr;
   logic [CH_W-1:0]       gnt;
   logic [NUM_CH-1:0]     gnt_oh;
   logic                  gnt_vld;
   logic                  load;

   // --------------------------------------------------------------------------
   // Event detection on the output of each synchroniser chain
   // --------------------------------------------------------------------------
   always_comb begin
      ev = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (TOGGLE_MODE != 0)
            ev[c] = en_sync[c][NUM_STAGES-1] ^ en_dly[c];
         else
            ev[c] = en_sync[c][NUM_STAGES-1] & ~en_dly[c];
      end
   end

   // --------------------------------------------------------------------------
   // Round-robin grant: search begins one past the last granted channel and
   // wraps, so the channel just served has the lowest priority next time.
   // --------------------------------------------------------------------------
   always_comb begin
      int              idx;
      logic [CH_W-1:0] sel;
      idx     = 0;
      sel     = '0;
      gnt     = '0;
      gnt_oh  = '0;
      gnt_vld = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = (int'(ptr) + i) % NUM_CH;
         sel = CH_W'(idx);
         if (!gnt_vld && pend[sel]) begin
            gnt_vld     = 1'b1;
            gnt         = sel;
            gnt_oh[sel] = 1'b1;
         end
      end
   end

   // The output register may take a new word when it is empty or when its
   // current word is being accepted this cycle.
   assign load = gnt_vld && (!sync_valid || out_ready);

   // --------------------------------------------------------------------------
   // Channel stage: synchronise, capture on event, track pending words.
   // A new event always wins over a same-cycle grant clear, so a word that
   // arrives as the previous one leaves is kept pending.
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int c = 0; c < NUM_CH; c++) begin
            en_sync[c] <= '0;
            hold[c]    <= '0;
         end
         en_dly <= '0;
         pend   <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            en_sync[c] <= {en_sync[c][NUM_STAGES-2:0], bus_enable[c]};
            en_dly[c]  <= en_sync[c][NUM_STAGES-1];
            if (ev[c]) begin
               hold[c] <= Unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
               pend[c] <= 1'b1;
            end else if (load && gnt_oh[c]) begin
               pend[c] <= 1'b0;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output stage: present one word at a time under valid/ready.
   // sync_bus keeps its last value after the word is accepted.
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_bus   <= '0;
         sync_ch    <= '0;
         sync_valid <= 1'b0;
         ptr        <= CH_W'(NUM_CH - 1);
      end else if (load) begin
         sync_bus   <= hold[gnt];
         sync_ch    <= gnt;
         sync_valid <= 1'b1;
         ptr        <= gnt;
      end else if (sync_valid && out_ready) begin
         sync_valid <= 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Overrun flags: a pending word replaced before it could be granted.
   // Being granted on the same edge as the new event is not an overrun, since
   // the old word leaves through the output register.
   // --------------------------------------------------------------------------
`ifdef DATA_SYNC_MC_OVERRUN_EN
   logic [NUM_CH-1:0] ovr_q;

   always_ff @(posedge CLK) begin
      if (RST)
         ovr_q <= '0;
      else
         ovr_q <= ovr_q | (ev & pend & ~({NUM_CH{load}} & gnt_oh));
   end

   assign overrun = ovr_q;
`else
   assign overrun = '0;
`endif

endmodule

// File: tb/tb_data_sync_mc.sv
// -----------------------------------------------------------------------------
// tb_data_sync_mc
//
// Directed bench for data_sync_mc. Two instances share clock and reset:
// dut0 uses rising-edge events (TOGGLE_MODE=0), dut1 uses toggle events
// (TOGGLE_MODE=1). Inputs change 1 time unit after the rising edge and
// outputs are checked at the same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_data_sync_mc;

   logic        clk;
   logic        rst;

   logic [31:0] data0, data1;
   logic [3:0]  en0, en1;
   logic        rdy0, rdy1;

   logic [7:0]  bus0, bus1;
   logic        valid0, valid1;
   logic [1:0]  ch0, ch1;
   logic [3:0]  ovr0, ovr1;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef DATA_SYNC_MC_OVERRUN_EN
   localparam logic [3:0] OVR_CH2 = 4'b0100;
`else
   localparam logic [3:0] OVR_CH2 = 4'b0000;
`endif

   data_sync_mc #(
      .NUM_CH(4), .BUS_WIDTH(8), .NUM_STAGES(2), .TOGGLE_MODE(0)
   ) dut0 (
      .CLK(clk), .RST(rst), .Unsync_bus(data0), .bus_enable(en0),
      .out_ready(rdy0), .sync_bus(bus0), .sync_valid(valid0),
      .sync_ch(ch0), .overrun(ovr0)
   );

   data_sync_mc #(
      .NUM_CH(4), .BUS_WIDTH(8), .NUM_STAGES(2), .TOGGLE_MODE(1)
   ) dut1 (
      .CLK(clk), .RST(rst), .Unsync_bus(data1), .bus_enable(en1),
      .out_ready(rdy1), .sync_bus(bus1), .sync_valid(valid1),
      .sync_ch(ch1), .overrun(ovr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_word0(input string tag, input logic v,
                              input logic [1:0] c, input logic [7:0] d);
      check({tag, "_v0"}, 32'(valid0), 32'(v));
      check({tag, "_ch0"}, 32'(ch0), 32'(c));
      check({tag, "_bus0"}, 32'(bus0), 32'(d));
   endtask

   task automatic check_word1(input string tag, input logic v,
                              input logic [1:0] c, input logic [7:0] d);
      check({tag, "_v1"}, 32'(valid1), 32'(v));
      check({tag, "_ch1"}, 32'(ch1), 32'(c));
      check({tag, "_bus1"}, 32'(bus1), 32'(d));
   endtask

   initial begin
      rst   = 1'b1;
      data0 = '0;  data1 = '0;
      en0   = '0;  en1   = '0;
      rdy0  = 1'b1;
      rdy1  = 1'b0;
      tick(2);

      // Reset state
      check_word0("rst", 1'b0, 2'd0, 8'h00);
      check_word1("rst", 1'b0, 2'd0, 8'h00);
      check("rst_ovr0", 32'(ovr0), 32'h0);
      check("rst_ovr1", 32'(ovr1), 32'h0);
      rst = 1'b0;
      tick(1);

      // Toggle mode: ch0 occupies a stalled output, ch2 toggles twice
      data1[7:0] = 8'h55;
      en1[0]     = 1'b1;
      tick(4);
      check_word1("tg_ch0", 1'b1, 2'd0, 8'h55);
      data1[23:16] = 8'h01;
      en1[2]       = 1'b1;
      tick(3);
      check_word1("tg_first", 1'b1, 2'd0, 8'h55);
      check("tg_ovr_first", 32'(ovr1), 32'h0);
      data1[23:16] = 8'h02;
      en1[2]       = 1'b0;
      tick(3);
      check_word1("tg_second", 1'b1, 2'd0, 8'h55);
      check("tg_ovr", 32'(ovr1), 32'(OVR_CH2));
      rdy1 = 1'b1;
      tick(1);
      check_word1("tg_out", 1'b1, 2'd2, 8'h02);
      tick(1);
      check("tg_drain_v1", 32'(valid1), 32'h0);
      check("tg_ovr_sticky", 32'(ovr1), 32'(OVR_CH2));
      check("tg_ovr0", 32'(ovr0), 32'h0);

      // Single-channel latency: enable sampled on the next edge E,
      // word valid after E+3 for exactly one cycle
      data0[15:8] = 8'hA5;
      en0[1]      = 1'b1;
      tick(3);
      check("lat_early_v0", 32'(valid0), 32'h0);
      tick(1);
      check_word0("lat", 1'b1, 2'd1, 8'hA5);
      tick(1);
      check("lat_one_v0", 32'(valid0), 32'h0);
      en0[1] = 1'b0;
      tick(4);
      check("fall_no_ev_v0", 32'(valid0), 32'h0);

      // Fresh pointer, then all four channels fire together
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      data0 = 32'h13121110;
      en0   = 4'hF;
      tick(4);
      check_word0("rr0", 1'b1, 2'd0, 8'h10);
      tick(1);
      check_word0("rr1", 1'b1, 2'd1, 8'h11);
      tick(1);
      check_word0("rr2", 1'b1, 2'd2, 8'h12);
      tick(1);
      check_word0("rr3", 1'b1, 2'd3, 8'h13);
      tick(1);
      check_word0("rr_idle", 1'b0, 2'd3, 8'h13);

      // Backpressure: outputs hold while out_ready is low
      en0  = 4'h0;
      rdy0 = 1'b0;
      tick(4);
      check("bp_idle_v0", 32'(valid0), 32'h0);
      data0[7:0]   = 8'h21;
      data0[31:24] = 8'h24;
      en0          = 4'b1001;
      tick(4);
      check_word0("bp_first", 1'b1, 2'd0, 8'h21);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check_word0("bp_hold", 1'b1, 2'd0, 8'h21);
      end
      rdy0 = 1'b1;
      tick(1);
      check_word0("bp_next", 1'b1, 2'd3, 8'h24);
      tick(1);
      check("bp_drain_v0", 32'(valid0), 32'h0);

      // Reset with words pending and presented, enables held high
      rdy0 = 1'b0;  rdy1 = 1'b0;
      en0  = 4'h0;  en1  = 4'h0;
      tick(4);
      data0 = 32'h33323130;
      data1 = 32'h33323130;
      en0   = 4'hF;
      en1   = 4'hF;
      tick(4);
      check_word0("pre_rst", 1'b1, 2'd0, 8'h30);
      rst = 1'b1;
      tick(1);
      check_word0("mid_rst", 1'b0, 2'd0, 8'h00);
      check_word1("mid_rst", 1'b0, 2'd0, 8'h00);
      check("mid_rst_ovr0", 32'(ovr0), 32'h0);
      check("mid_rst_ovr1", 32'(ovr1), 32'h0);
      rst  = 1'b0;
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      tick(3);
      check("rel_early_v0", 32'(valid0), 32'h0);
      check("rel_early_v1", 32'(valid1), 32'h0);
      for (int c = 0; c < 4; c++) begin
         tick(1);
         check_word0("rel", 1'b1, 2'(c), 8'(8'h30 + c));
         check_word1("rel", 1'b1, 2'(c), 8'(8'h30 + c));
      end
      tick(1);
      check("rel_done_v0", 32'(valid0), 32'h0);
      check("rel_done_v1", 32'(valid1), 32'h0);
      tick(4);
      check("rel_once_v0", 32'(valid0), 32'h0);
      check("rel_once_v1", 32'(valid1), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
